instr_fetch: RTL

Fetch stage of the 16-bit RISC core. It owns the program counter and fetches one 16-bit instruction per step from instruction memory over a req/ack handshake. It holds the instruction in an instruction register and presents its opcode and fields to the decoder/control stage. It also consumes the decoder's `jump`/`jeq`/`jr` outputs to select the next PC.

---
 rtl/instr_fetch.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//   Fetch stage of the 16-bit RISC core. Owns the program counter, fetches
//   one 16-bit instruction per step over a req/ack handshake, holds it in the
//   instruction register (IR) and presents its fields to decode/control.
//   The decoder's jump/jeq/jr selects are consumed in EXEC to form the next PC.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   imem_req        : fetch request, held until imem_ack
//   imem_addr       : fetch word address (always equals pc)
//   imem_ack        : memory acknowledge, imem_rdata valid in the same cycle
//   imem_rdata      : fetched instruction word
//   jump, jeq, jr   : decoder next-PC selects (priority jr > jump > jeq)
//   eq_flag         : equality flag from the last CMP, used by jeq
//   jr_target       : register value used by jr
//   exec_stall      : downstream busy, holds the block in EXEC
//   pc              : current program counter
//   instr           : instruction register
//   opcode,rd,rs,rt : IR[15:12], IR[11:8], IR[7:4], IR[3:0]
//   instr_valid     : high while in EXEC (IR architecturally live)
// ---------------------------------------------------------------------------
module instr_fetch #(
    parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    input  logic        jump,
    input  logic        jeq,
    input  logic        jr,
    input  logic        eq_flag,
    input  logic [15:0] jr_target,
    input  logic        exec_stall,
    output logic [15:0] pc,
    output logic [15:0] instr,
    output logic [3:0]  opcode,
    output logic [3:0]  rd,
    output logic [3:0]  rs,
    output logic [3:0]  rt,
    output logic        instr_valid
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;

    // Sign-extend the 12-bit branch displacement held in IR[11:0].
    function automatic logic signed [15:0] sext12(input logic [11:0] v);
        logic signed [15:0] ext;
        ext = {{4{v[11]}}, v};
        return ext;
    endfunction

    // Next-PC selection. Priority is fixed even for illegal multi-select
    // combinations; all adds wrap modulo 2^16.
    function automatic logic [15:0] calc_next_pc(
        input logic [15:0] cur_pc,
        input logic [15:0] ir,
        input logic        sel_jump,
        input logic        sel_jeq,
        input logic        sel_jr,
        input logic        eq,
        input logic [15:0] target
    );
        logic        [15:0] pc_plus1;
        logic signed [15:0] disp;
        logic        [15:0] result;
        pc_plus1 = cur_pc + 16'd1;
        disp     = sext12(ir[11:0]);
        if (sel_jr) begin
            result = target;
        end else if (sel_jump) begin
            // Absolute jump stays within the 4K page of the following word.
            result = {pc_plus1[15:12], ir[11:0]};
        end else if (sel_jeq && eq) begin
            result = pc_plus1 + $unsigned(disp);
        end else begin
            result = pc_plus1;
        end
        return result;
    endfunction

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                // Ack only matters here; a stray ack elsewhere never loads IR.
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!exec_stall) begin
                    pc_d    = calc_next_pc(pc_q, ir_q, jump, jeq, jr,
                                           eq_flag, jr_target);
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_VECTOR;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Every output is a flop or a decode of the state register only.
    assign imem_req    = (state_q == ST_FETCH);
    assign instr_valid = (state_q == ST_EXEC);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = ir_q;
    assign opcode      = ir_q[15:12];
    assign rd          = ir_q[11:8];
    assign rs          = ir_q[7:4];
    assign rt          = ir_q[3:0];

endmodule
